// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 operand/result mux.
// Optional forced release after HOLD_MAX cycles when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       win_found;
  logic [3:0] win_onehot;
  logic       owner_req;
  logic       force_rel;

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_params
    $error("mux4_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
  end

  // Scan ptr+1, ptr+2, ptr+3, ptr so the last winner has lowest priority.
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == 2'(gi));
  end

  assign owner_req = req[sel_q];

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_rel = (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = win_onehot;
          sel_d   = win_idx;
          busy_d  = 1'b1;
          ptr_d   = win_idx;
        end
      end
      GRANT: begin
        // sel is left alone on release so the mux output stays stable one more cycle.
        if (done || !owner_req) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end else if (force_rel) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table plus hand-written reset and
// hold/timeout sequences, all checked through an expected-value queue.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  mux4_rr_arbiter #(
    .HOLD_MAX(4),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input logic [3:0] g, input logic [1:0] s, input logic b,
                          input logic t, input string tag);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.busy = b;
    e.tmo  = t;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got gnt=%b sel=%0d busy=%b timeout=%b, required a queued expectation",
               gnt, sel, busy, timeout);
      return;
    end
    e = exp_q.pop_front();
    if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy || timeout !== e.tmo) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, required gnt=%b sel=%0d busy=%b timeout=%b",
               e.tag, gnt, sel, busy, timeout, e.gnt, e.sel, e.busy, e.tmo);
    end else begin
      $display("ok   %s: gnt=%b sel=%0d busy=%b timeout=%b", e.tag, gnt, sel, busy, timeout);
    end
  endtask

  // Drive inputs at the falling edge, compare 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic [3:0] q, input logic d,
                      input logic [3:0] g, input logic [1:0] s, input logic b,
                      input logic t, input string tag);
    @(negedge clk);
    rst  = r;
    req  = q;
    done = d;
    push_exp(g, s, b, t, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  localparam int NVEC = 29;
  vec_t vecs[NVEC];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {rst, req, done, gnt, sel, busy, timeout}
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    // Round robin with done held high (ignored while idle)
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    // Non-owner request ignored, then skip and wrap from ptr=2
    vecs[12] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    // Release by request drop; sel holds
    vecs[18] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    // done and request drop together, another requester waiting
    vecs[20] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    // Lone requester re-granted every 2 cycles
    vecs[24] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[27] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    push_exp(4'b0000, 2'd0, 1'b0, 1'b0, "reset_state");
    @(posedge clk);
    #1;
    check_pop();

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done,
           vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].tmo,
           $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a grant to requester 2
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "pre_async_rst");
    #2;
    rst = 1'b1;
    push_exp(4'b0000, 2'd0, 1'b0, 1'b0, "async_rst_immediate");
    #1;
    check_pop();
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "first_grant_after_rst");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "release_after_rst");

    // Long hold by requester 2 with requester 0 pending
    step(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_grant");
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("hold_cycle%0d", i));
    end
    step(1'b0, 4'b0101, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, "timeout_pulse");
    step(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "grant_after_timeout");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "final_release");
`else
    for (int i = 1; i <= 110; i++) begin
      step(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("hold_cycle%0d", i));
    end
    step(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "final_release");
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 operand/result mux among four requesters.
- Owns the mux select: it grants one requester at a time, holds the grant for a multi-cycle transaction, and drives the mux S input from registered state.
- Sits between requester units (e.g. ALU, load/store, branch, debug) and the shared bus mux in the datapath.

Parameters:
- HOLD_MAX, 16, maximum grant length in cycles before forced release (used only with the timeout feature); legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per requester; bit i = requester i; level-sensitive, held until served
- done  input  1  owner's end-of-transaction pulse, sampled only in GRANT
- gnt  output  4  registered one-hot grant; all zeros when idle
- sel  output  2  registered mux select; drives the 4:1 mux S input
- busy  output  1  registered, high while in GRANT
- timeout  output  1  one-cycle pulse on forced release (tied 0 without the optional feature)

Behaviour:
- Reset (async, active-high): state=IDLE, gnt=4'b0000, sel=2'd0, busy=0, timeout=0, ptr=2'd3 (last winner), hold counter=0. All outputs are at these values while rst=1 and take effect immediately, not at the next edge.
- State machine has two states: IDLE and GRANT.
- IDLE with req==0:
  - Stay in IDLE; outputs unchanged (gnt=0, busy=0).
  - sel keeps its last value.
- IDLE with req!=0:
  - Winner = first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - At that edge: gnt=onehot(winner), sel=winner, busy=1, ptr=winner, counter=0, state goes to GRANT.
  - Latency: req sampled at edge N gives gnt valid after edge N.
- GRANT release: at an edge where done=1 or req[sel]=0, go to IDLE with gnt=0 and busy=0.
  - sel holds the old value, so the mux output stays stable for one cycle.
- GRANT otherwise: stay in GRANT; counter increments and saturates at 2^CNT_W-1.
- Arbitration does not happen in the release cycle. There is a minimum of one IDLE cycle between grants, and the next arbitration occurs at the following edge.
- Requests from non-owners during GRANT are ignored. They are not latched; they must stay asserted to be served.
- done asserted in IDLE is ignored.
- With a single requester continuously requesting and pulsing done, that requester is re-granted every 2 cycles.
- With all four requesting continuously, grant order is 0,1,2,3,0,... No requester waits more than 3 grants.
- Owner dropping req in the same cycle as done: single release, no double event.
- gnt is always one-hot or zero. sel == index of gnt whenever busy=1.
- Reset asserted mid-GRANT: immediate return to the reset values, and ptr=3 (the requester 0 bias is restored).

Optional Feature:
- Macro: MUX4_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if counter==HOLD_MAX-1 and neither done nor req[sel]=0, force release at that edge.
  - At the same edge: gnt=0, busy=0, state=IDLE, timeout=1 for exactly one cycle.
  - A grant therefore lasts at most HOLD_MAX cycles.
  - ptr is already the owner, so the next arbitration skips to the next requester.
  - Normal release takes precedence: if done=1 at the limit cycle, timeout stays 0.
- Undefined: no forced release; the counter logic may be omitted; timeout is tied to 0; the grant lasts until done or req drop.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while gnt=4'b0100 -> gnt=0, sel=0 and busy=0 immediately; first grant after reset with req=4'b1111 is gnt=4'b0001.
- Round robin: req=4'b1111 held, done pulsed each GRANT cycle -> gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; sel tracks 0,1,2,3,0.
- Skip and wrap: ptr=2 (last winner 2), req=4'b0011 -> gnt=4'b0001; after release with req=4'b0011 still asserted -> gnt=4'b0010.
- Drop release: grant to requester 1, deassert req[1] without done -> next cycle gnt=0 and busy=0; sel stays 1 during that IDLE cycle.
- Simultaneous events: done=1 and req[owner]=0 in the same cycle while req of another requester=1 -> exactly one IDLE cycle, then the new requester is granted; no timeout pulse.
- Timeout (MUX4_ARB_TIMEOUT_EN, HOLD_MAX=4): requester 2 granted, holds req with no done -> gnt=4'b0100 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle; with req=4'b0101 pending, the next grant is 4'b0001. Without the macro, the grant persists for over 100 cycles and timeout stays 0.
